// File: rtl/shift_counter_sequencer_pkg.sv
// Shared definitions for the shift-register counter sequencer: mode codes,
// FSM state encoding and the ring-mode zero-seed substitute.
package shift_counter_sequencer_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Single 1 in the first stage (bit width-1), so a ring never locks at zero.
  function automatic logic [MAX_WIDTH-1:0] ring_zero_seed(input int unsigned width);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

// File: rtl/shift_counter_sequencer_if.sv
// Command handshake and status bundle between a host sequencer and the
// shift-register counter controller.
interface shift_counter_sequencer_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [WIDTH-1:0]  cmd_seed;
  logic [STEP_W-1:0] cmd_steps;
  logic              abort;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_done;

  modport master (
    output cmd_valid, cmd_mode, cmd_seed, cmd_steps, abort,
    input  cmd_ready, q, busy, done, steps_done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_seed, cmd_steps, abort,
    output cmd_ready, q, busy, done, steps_done
  );

endinterface

// File: rtl/shift_counter_core.sv
// WIDTH-bit shift register with synchronous clear, parallel load and a
// ring/Johnson feedback selected by mode; q[WIDTH-1] is the first stage.
module shift_counter_core
  import shift_counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             shift_en,
  input  logic             mode,
  output logic [WIDTH-1:0] q
);

  logic feedback;

  always_comb begin
    feedback = (mode == MODE_JOHNSON) ? ~q[0] : q[0];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (shift_en) begin
      q <= {feedback, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_counter_sequencer.sv
// Command-driven controller: accepts mode/seed/steps, shifts the counter
// once per clock for the requested steps, then pulses done for one cycle.
module shift_counter_sequencer
  import shift_counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic                     clk,
  input  logic                     clear,
  shift_counter_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] RING_ZERO_SEED = WIDTH'(ring_zero_seed(WIDTH));

  state_e            state, state_nx;
  logic              mode_r;
  logic [STEP_W-1:0] steps_r;
  logic [STEP_W-1:0] steps_done_r;
  logic [STEP_W-1:0] steps_inc;
  logic              accept;
  logic              load;
  logic              shift_en;
  logic [WIDTH-1:0]  load_seed;

  always_comb begin
    steps_inc = steps_done_r + STEP_W'(1);
    load_seed = (bus.cmd_mode == MODE_RING && bus.cmd_seed == '0) ? RING_ZERO_SEED
                                                                  : bus.cmd_seed;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // abort takes priority over the final-step exit, so no shift happens on that edge.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept   = 1'b1;
          load     = 1'b1;
          state_nx = (bus.cmd_steps != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_nx = ST_DONE;
        end else begin
          shift_en = 1'b1;
          if (steps_inc == steps_r) begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      mode_r       <= MODE_RING;
      steps_r      <= '0;
      steps_done_r <= '0;
    end else if (accept) begin
      mode_r       <= bus.cmd_mode;
      steps_r      <= bus.cmd_steps;
      steps_done_r <= '0;
    end else if (shift_en) begin
      steps_done_r <= steps_inc;
    end
  end

  shift_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .clear    (clear),
    .load     (load),
    .seed     (load_seed),
    .shift_en (shift_en),
    .mode     (mode_r),
    .q        (bus.q)
  );

  assign bus.cmd_ready  = (state == ST_IDLE);
  assign bus.busy       = (state == ST_RUN);
  assign bus.done       = (state == ST_DONE);
  assign bus.steps_done = steps_done_r;

endmodule

// File: tb/tb_shift_counter_sequencer.sv
// Randomized self-checking bench; expected q comes from a rotation model
// (Johnson of width W == top half of a 2W ring holding {seed, ~seed}).
module tb_shift_counter_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 8;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic clk = 1'b0;
  logic clear;

  shift_counter_sequencer_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  shift_counter_sequencer #(
    .WIDTH  (W),
    .STEP_W (SW)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected counter value after n shifts from a freshly accepted seed.
  function automatic logic [W-1:0] exp_q(input logic mode, input logic [W-1:0] seed,
                                         input int unsigned n);
    logic [W-1:0]   s;
    logic [2*W-1:0] r2;
    logic [2*W-1:0] j2;
    logic [4*W-1:0] j4;
    s = seed;
    if (mode == 1'b0 && seed == '0) s = {1'b1, {(W-1){1'b0}}};
    if (mode == 1'b0) begin
      r2 = {s, s} >> (n % W);
      return r2[W-1:0];
    end
    j2 = {s, ~s};
    j4 = {j2, j2} >> (n % (2*W));
    return j4[2*W-1:W];
  endfunction

  task automatic check_status(input string tag, input logic rdy, input logic bsy,
                              input logic dn, input logic [W-1:0] q,
                              input int unsigned sd);
    check_eq({tag, "_ready"}, 32'(bus.cmd_ready), 32'(rdy));
    check_eq({tag, "_busy"},  32'(bus.busy),      32'(bsy));
    check_eq({tag, "_done"},  32'(bus.done),      32'(dn));
    check_eq({tag, "_q"},     32'(bus.q),         32'(q));
    check_eq({tag, "_steps"}, 32'(bus.steps_done), sd);
  endtask

  // One full command; abort_after = shift count at which abort is raised (-1: never).
  task automatic run_cmd(input logic mode, input logic [W-1:0] seed,
                         input int unsigned steps, input int abort_after,
                         input bit noise);
    int unsigned n;
    bit running;
    @(negedge clk);
    check_eq("idle_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_seed  = seed;
    bus.cmd_steps = SW'(steps);
    bus.abort     = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    running = (steps != 0);
    while (running) begin
      check_status("run", 1'b0, 1'b1, 1'b0, exp_q(mode, seed, n), n);
      if (noise) begin
        bus.cmd_valid = 1'($urandom);
        bus.cmd_mode  = 1'($urandom);
        bus.cmd_seed  = W'($urandom);
        bus.cmd_steps = SW'($urandom);
      end
      if (abort_after == int'(n)) begin
        bus.abort = 1'b1;
        running = 0;
      end else begin
        bus.abort = 1'b0;
        n++;
        if (n == steps) running = 0;
      end
      @(negedge clk);
    end
    check_status("done", 1'b0, 1'b0, 1'b1, exp_q(mode, seed, n), n);
    bus.abort     = noise ? 1'($urandom) : 1'b0;
    bus.cmd_valid = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    check_status("back_idle", 1'b1, 1'b0, 1'b0, exp_q(mode, seed, n), n);
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
  endtask

  initial begin
    clear         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 1'b0;
    bus.cmd_seed  = '0;
    bus.cmd_steps = '0;
    bus.abort     = 1'b0;
    repeat (2) @(negedge clk);
    check_status("reset", 1'b1, 1'b0, 1'b0, 4'b0000, 0);
    clear = 1'b0;

    // Directed cases from the expected sequences.
    run_cmd(1'b1, 4'b0000, 8, -1, 1'b0);
    check_eq("johnson8_final", 32'(bus.q), 32'(4'b0000));
    check_eq("johnson8_steps", 32'(bus.steps_done), 32'd8);
    run_cmd(1'b0, 4'b0001, 5, -1, 1'b0);
    check_eq("ring5_final", 32'(bus.q), 32'(4'b1000));
    run_cmd(1'b0, 4'b0000, 2, -1, 1'b0);
    check_eq("ring_zero_final", 32'(bus.q), 32'(4'b0010));
    run_cmd(1'b1, 4'b1010, 0, -1, 1'b0);
    check_eq("zero_steps_q", 32'(bus.q), 32'(4'b1010));
    run_cmd(1'b1, 4'b0000, 10, 3, 1'b0);
    check_eq("abort3_final", 32'(bus.q), 32'(4'b1110));
    check_eq("abort3_steps", 32'(bus.steps_done), 32'd3);
    run_cmd(1'b1, 4'b0000, 2, 1, 1'b0);
    check_eq("abort_last_steps", 32'(bus.steps_done), 32'd1);
    check_eq("abort_last_q", 32'(bus.q), 32'(4'b1000));

    // clear mid-run, with a cmd_valid pulse while busy.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 1'b1;
    bus.cmd_seed  = 4'b0000;
    bus.cmd_steps = 8'd10;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_seed  = 4'b1010;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_eq("busy_valid_ignored", 32'(bus.q), 32'(4'b1110));
    @(negedge clk);
    check_eq("pre_clear_q", 32'(bus.q), 32'(4'b1111));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_status("mid_clear", 1'b1, 1'b0, 1'b0, 4'b0000, 0);
    @(negedge clk);
    check_eq("no_done_after_clear", 32'(bus.done), 32'd0);

    // Randomized commands with noise on ignored inputs.
    for (int i = 0; i < 60; i++) begin
      logic m;
      logic [W-1:0] s;
      int unsigned st;
      int ab;
      m  = 1'($urandom);
      s  = W'($urandom);
      st = ($urandom_range(0, 4) == 0) ? $urandom_range(13, 30) : $urandom_range(0, 12);
      ab = (st != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, st - 1)) : -1;
      run_cmd(m, s, st, ab, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_counter_sequencer.md
Name: shift_counter_sequencer

Overview:
Command-driven controller for a WIDTH-bit shift-register counter that can run as a ring counter or a Johnson counter. It accepts a command (mode, seed, step count) over a valid/ready handshake, loads the seed and shifts once per clock for the requested number of steps. It then reports completion with a one-cycle done pulse. It sits between a host/testbench sequencer and the counter datapath, replacing ad-hoc per-stage set/clear driving.

Parameters:
WIDTH, 4, number of counter stages (>= 2)
STEP_W, 8, width of step count and step counter

Ports:
clk  input  1  rising-edge clock
clear  input  1  reset, synchronous, active-high; overrides all other inputs
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_mode  input  1  0 = ring, 1 = Johnson
cmd_seed  input  WIDTH  initial counter value
cmd_steps  input  STEP_W  number of shifts to perform
abort  input  1  stop the current run early
q  output  WIDTH  counter state; q[WIDTH-1] is the first stage
busy  output  1  high in RUN
done  output  1  one-cycle completion pulse
steps_done  output  STEP_W  shifts performed in the current or last run

Behaviour:
- Reset (clear=1 at posedge): state IDLE, q=0, busy=0, done=0, cmd_ready=1, steps_done=0. Applies mid-run; the run is discarded and no done pulse is issued.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- IDLE:
  - Accept on the posedge where cmd_valid && cmd_ready. On that edge: latch mode and steps, load q, set steps_done=0.
  - Next state is RUN if cmd_steps != 0, else DONE.
- Seed rule:
  - Ring mode with cmd_seed == 0 loads a single 1 in the first stage ({1'b1, zeros}), so the ring never locks at zero.
  - Johnson mode loads cmd_seed as-is. Non-Johnson codes are not corrected.
- Shift (RUN, per posedge):
  - Ring: q <= {q[0], q[WIDTH-1:1]}.
  - Johnson: q <= {~q[0], q[WIDTH-1:1]}.
  - steps_done increments by 1.
  - When the incremented value equals the latched steps, go to DONE.
- Latency: with N >= 1 steps accepted at edge E0, the shifts occur at E1..EN. busy=1 for N cycles. done=1 in the cycle following EN. IDLE is re-entered at EN+1.
- DONE lasts exactly one cycle: done=1, busy=0, cmd_ready=0.
- q and steps_done hold their values through DONE and IDLE until the next accept.
- abort:
  - Sampled only in RUN. On that edge there is no shift and no increment, and the state goes to DONE.
  - abort on the same edge as the final step: abort wins, so the final shift is not performed.
  - Ignored in IDLE and DONE.
- cmd_valid outside IDLE is ignored. No queuing; the requester must hold cmd_valid until accepted.
- Periods: the ring period is WIDTH; the Johnson period is 2*WIDTH. Counts beyond one period wrap naturally.
- steps_done never exceeds the latched steps. There is no overflow, because it stops at steps <= 2^STEP_W-1.

Decomposition:
- Shared package:
  - MODE_RING=1'b0, MODE_JOHNSON=1'b1.
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Ring zero-seed substitute value, as a function of WIDTH.
- One sub-module, shift_counter_core:
  - Contains the WIDTH-bit register with clear, load (with seed), shift_en and mode inputs.
  - Implements the ring/Johnson feedback.
  - The FSM and step counter stay in shift_counter_sequencer.

Test Plan:
1. clear for 2 cycles, then Johnson, seed 0000, steps 8 -> q: 1000,1100,1110,1111,0111,0011,0001,0000; busy for 8 cycles; done pulse 1 cycle; steps_done=8; cmd_ready back to 1 the following cycle.
2. Ring, seed 0001, steps 5 -> q: 1000,0100,0010,0001,1000; final q=1000; steps_done=5.
3. Ring, seed 0000, steps 2 -> load 1000, then 0100, 0010; final q=0010.
4. Any mode, seed 1010, steps 0 -> q=1010 after accept; done the next cycle; busy never high; steps_done=0.
5. Johnson, seed 0000, steps 10; abort asserted after the 3rd shift -> q=1110; steps_done=3; done pulse; IDLE. Second run: abort on the same edge as the final step of steps 2 -> only 1 shift; steps_done=1.
6. clear during RUN (Johnson, 4 shifts in) -> next cycle q=0000, busy=0, cmd_ready=1, no done pulse. A cmd_valid pulse while busy is not accepted; q is unaffected.
